// File: rtl/uart_debug_unit.sv
// uart_debug_unit: UART byte-command debug controller that loads instruction
// memory, runs or single-steps the CPU, and streams a register dump back out.
module uart_debug_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int N_DUMP     = 4,
    parameter bit BIG_ENDIAN = 1,
    localparam int SEL_W     = (N_DUMP > 1) ? $clog2(N_DUMP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              is_rx_done,
    input  logic              is_tx_done,
    output logic [7:0]        o_tx_data,
    output logic              os_tx_start,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_data,
    output logic              o_cpu_en,
    input  logic              i_cpu_halt,
    output logic [SEL_W-1:0]  o_dump_sel,
    input  logic [DATA_W-1:0] i_dump_data
);
    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
    localparam logic [SEL_W-1:0] LAST_S = SEL_W'(N_DUMP - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP_WAIT, STEP_EXEC, DUMP_REQ, DUMP_WAIT} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [BW-1:0]     byte_cnt, byte_idx;
    logic [DATA_W-1:0] asm_q, asm_nx;
    logic [7:0]        dump_byte;
    logic              ack, step, last, word_done;

    // The same byte counter orders both load assembly and dump serialisation.
    assign byte_idx  = BIG_ENDIAN ? LAST_B - byte_cnt : byte_cnt;
    assign dump_byte = i_dump_data[8*byte_idx +: 8];
    assign word_done = state == LOAD && is_rx_done && byte_cnt == LAST_B;

    always_comb begin
        asm_nx = asm_q;
        asm_nx[8*byte_idx +: 8] = i_rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (is_rx_done) state_nx = i_rx_data == 8'h01 ? LOAD :
                                                  i_rx_data == 8'h02 ? RUN :
                                                  i_rx_data == 8'h03 ? STEP_WAIT : IDLE;
            LOAD:      if (word_done && (asm_nx == '1 || addr == '1)) state_nx = DUMP_REQ;
            RUN:       if (i_cpu_halt) state_nx = DUMP_REQ;
            STEP_WAIT: if (is_rx_done) state_nx = i_rx_data == 8'h73 ? STEP_EXEC :
                                                  i_rx_data == 8'h71 ? IDLE : STEP_WAIT;
            STEP_EXEC: state_nx = DUMP_REQ;
            DUMP_REQ:  state_nx = DUMP_WAIT;
            DUMP_WAIT: if (is_tx_done) state_nx = !last ? DUMP_REQ :
                                                  (step && !ack && !i_cpu_halt) ? STEP_WAIT : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_cpu_en    = (state == RUN || state == STEP_EXEC) && !i_cpu_halt;
        os_tx_start = state == DUMP_REQ;
    end

    // Dump select advances while its last byte is in flight, so i_dump_data
    // has settled by the time the next byte is latched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr        <= '0;
            byte_cnt    <= '0;
            asm_q       <= '0;
            ack         <= 1'b0;
            step        <= 1'b0;
            last        <= 1'b0;
            o_tx_data   <= 8'h00;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_dump_sel  <= '0;
        end else begin
            o_imem_we <= 1'b0;
            if (state == IDLE && is_rx_done) begin
                ack  <= i_rx_data == 8'h01;
                step <= i_rx_data == 8'h03;
                if (i_rx_data == 8'h01) addr <= '0;
            end
            if (state == LOAD && is_rx_done) begin
                asm_q    <= asm_nx;
                byte_cnt <= byte_cnt == LAST_B ? '0 : byte_cnt + 1'b1;
                if (byte_cnt == LAST_B) begin
                    o_imem_we   <= 1'b1;
                    o_imem_addr <= addr;
                    o_imem_data <= asm_nx;
                    if (addr != '1) addr <= addr + 1'b1;
                end
            end
            if (state_nx == DUMP_REQ) o_tx_data <= ack ? 8'hA5 : dump_byte;
            if (state == DUMP_REQ) begin
                last <= ack || (o_dump_sel == LAST_S && byte_cnt == LAST_B);
                if (!ack) begin
                    byte_cnt <= byte_cnt == LAST_B ? '0 : byte_cnt + 1'b1;
                    if (byte_cnt == LAST_B) o_dump_sel <= o_dump_sel == LAST_S ? '0 : o_dump_sel + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_debug_unit.sv
// tb_uart_debug_unit: scoreboard bench for the default configuration and a
// 16-bit little-endian, 2-bit-address configuration.
module tb_uart_debug_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  rx_a = 8'h00, tx_a, iaddr_a;
    logic        rxd_a = 1'b0, txd_a = 1'b0, halt_a = 1'b0;
    logic        start_a, we_a, en_a;
    logic [31:0] idata_a, dump_a;
    logic [1:0]  sel_a;
    assign dump_a = 32'h11223344 + 32'(sel_a);

    logic [7:0]  rx_b = 8'h00, tx_b;
    logic        rxd_b = 1'b0, txd_b = 1'b0, halt_b = 1'b0;
    logic        start_b, we_b, en_b, sel_b;
    logic [1:0]  iaddr_b;
    logic [15:0] idata_b, dump_b;
    assign dump_b = 16'h0000;

    uart_debug_unit dut_a (
        .clk(clk), .rst(rst), .i_rx_data(rx_a), .is_rx_done(rxd_a), .is_tx_done(txd_a),
        .o_tx_data(tx_a), .os_tx_start(start_a), .o_imem_we(we_a), .o_imem_addr(iaddr_a),
        .o_imem_data(idata_a), .o_cpu_en(en_a), .i_cpu_halt(halt_a), .o_dump_sel(sel_a),
        .i_dump_data(dump_a)
    );

    uart_debug_unit #(.DATA_W(16), .ADDR_W(2), .N_DUMP(1), .BIG_ENDIAN(0)) dut_b (
        .clk(clk), .rst(rst), .i_rx_data(rx_b), .is_rx_done(rxd_b), .is_tx_done(txd_b),
        .o_tx_data(tx_b), .os_tx_start(start_b), .o_imem_we(we_b), .o_imem_addr(iaddr_b),
        .o_imem_data(idata_b), .o_cpu_en(en_b), .i_cpu_halt(halt_b), .o_dump_sel(sel_b),
        .i_dump_data(dump_b)
    );

    int checks = 0, errors = 0, en_cnt_a = 0, cd_a = 0, cd_b = 0;
    logic [47:0] qa[$], qb[$];

    function automatic logic [47:0] wr(input logic [7:0] a, input logic [31:0] d);
        return {8'd1, a, d};
    endfunction

    function automatic logic [47:0] tx(input logic [7:0] b);
        return {8'd2, 8'd0, 24'd0, b};
    endfunction

    task automatic chk(input string n, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic ev_a(input logic [47:0] g);
        if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected got=%h exp=none", g);
        end else chk("a_event", g, qa.pop_front());
    endtask

    task automatic ev_b(input logic [47:0] g);
        if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected got=%h exp=none", g);
        end else chk("b_event", g, qb.pop_front());
    endtask

    initial forever begin
        @(negedge clk);
        if (we_a) ev_a(wr(iaddr_a, idata_a));
        if (start_a) ev_a(tx(tx_a));
        if (en_a) en_cnt_a++;
        if (we_b) ev_b(wr(8'(iaddr_b), 32'(idata_b)));
        if (start_b) ev_b(tx(tx_b));
    end

    // Transmitter models: finish each byte four cycles after its start.
    initial forever begin
        @(negedge clk);
        txd_a = cd_a == 1;
        if (cd_a > 0) cd_a--;
        if (start_a) begin
            checks++;
            if (cd_a != 0) begin errors++; $display("FAIL a_tx_gate busy=%0d exp=0", cd_a); end
            cd_a = 4;
        end
    end

    initial forever begin
        @(negedge clk);
        txd_b = cd_b == 1;
        if (cd_b > 0) cd_b--;
        if (start_b) begin
            checks++;
            if (cd_b != 0) begin errors++; $display("FAIL b_tx_gate busy=%0d exp=0", cd_b); end
            cd_b = 4;
        end
    end

    task automatic send_a(input logic [7:0] b);
        @(negedge clk); rx_a = b; rxd_a = 1'b1;
        @(negedge clk); rxd_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] b);
        @(negedge clk); rx_b = b; rxd_b = 1'b1;
        @(negedge clk); rxd_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 3000 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
        chk(n, 48'(qa.size() + qb.size()), 48'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic push_dump(input int nbytes);
        logic [31:0] v;
        for (int i = 0; i < nbytes; i++) begin
            v = 32'h11223344 + 32'(i / 4);
            qa.push_back(tx(v[8*(3 - i % 4) +: 8]));
        end
    endtask

    task automatic run_to_halt(input int n);
        int i;
        for (i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (en_cnt_a >= n) break;
        end
        chk("run_budget", 48'(i < 500), 48'd1);
        halt_a = 1'b1;
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_tx_data"}, 48'(tx_a), 48'd0);
        chk({n, "_tx_start"}, 48'(start_a), 48'd0);
        chk({n, "_we"}, 48'(we_a), 48'd0);
        chk({n, "_addr"}, 48'(iaddr_a), 48'd0);
        chk({n, "_data"}, 48'(idata_a), 48'd0);
        chk({n, "_cpu_en"}, 48'(en_a), 48'd0);
        chk({n, "_sel"}, 48'(sel_a), 48'd0);
    endtask

    initial begin
        #3 rst = 1'b0;
        #20;
        chk_zero("rst_a");
        chk("rst_b_we", 48'(we_b), 48'd0);
        chk("rst_b_start", 48'(start_b), 48'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);

        // Load: an ignored byte, then three words ending in the halt word.
        send_a(8'h55);
        qa.push_back(wr(8'd0, 32'h00000001));
        qa.push_back(wr(8'd1, 32'h00000002));
        qa.push_back(wr(8'd2, 32'hFFFFFFFF));
        qa.push_back(tx(8'hA5));
        send_a(8'h01);
        send_a(8'h00); send_a(8'h00); send_a(8'h00); send_a(8'h01);
        send_a(8'h00); send_a(8'h00); send_a(8'h00); send_a(8'h02);
        send_a(8'hFF); send_a(8'hFF); send_a(8'hFF); send_a(8'hFF);
        drain("load_drain");

        // Run for ten enabled cycles; a 0x01 during the dump must be discarded.
        en_cnt_a = 0;
        push_dump(16);
        send_a(8'h02);
        run_to_halt(10);
        send_a(8'h01);
        drain("run_drain");
        chk("run_en_cycles", 48'(en_cnt_a), 48'd10);

        // Two steps, then quit; a later 0x73 in IDLE does nothing.
        halt_a = 1'b0;
        en_cnt_a = 0;
        push_dump(16);
        send_a(8'h03);
        send_a(8'h73);
        drain("step1_drain");
        chk("step1_en", 48'(en_cnt_a), 48'd1);
        push_dump(16);
        send_a(8'h73);
        drain("step2_drain");
        chk("step2_en", 48'(en_cnt_a), 48'd2);
        send_a(8'h71);
        send_a(8'h73);
        repeat (30) @(negedge clk);
        chk("step_quit_en", 48'(en_cnt_a), 48'd2);

        // Reset while the third dump byte is outstanding, then rerun.
        en_cnt_a = 0;
        push_dump(3);
        send_a(8'h02);
        run_to_halt(5);
        for (int i = 0; i < 500 && qa.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("mid_dump_rst");
        chk("mid_dump_en", 48'(en_cnt_a), 48'd5);
        repeat (3) @(negedge clk);
        chk_zero("held_rst");
        rst = 1'b1;
        halt_a = 1'b0;
        repeat (10) @(negedge clk);
        en_cnt_a = 0;
        push_dump(16);
        send_a(8'h02);
        run_to_halt(4);
        drain("rerun_drain");
        chk("rerun_en", 48'(en_cnt_a), 48'd4);

        // 16-bit little-endian load.
        qb.push_back(wr(8'd0, 32'h00001234));
        qb.push_back(wr(8'd1, 32'h0000FFFF));
        qb.push_back(tx(8'hA5));
        send_b(8'h01);
        send_b(8'h34); send_b(8'h12);
        send_b(8'hFF); send_b(8'hFF);
        drain("le_drain");

        // Address exhaustion at 2^2 words; a fifth word is ignored.
        for (int i = 0; i < 4; i++) qb.push_back(wr(8'(i), 32'(i + 1)));
        qb.push_back(tx(8'hA5));
        send_b(8'h01);
        for (int i = 1; i <= 5; i++) begin
            send_b(8'(i));
            send_b(8'h00);
        end
        repeat (30) @(negedge clk);
        chk("exhaust_left", 48'(qb.size()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
